// File: rtl/lab3_cache_victim_buffer_pkg.sv
// lab3_cache_victim_buffer_pkg: shared line geometry, memory message types and FSM states for the victim buffer
package lab3_cache_victim_buffer_pkg;
   localparam int WORDS_PER_LINE = 16;
   localparam int LINE_OFFSET_BITS = 6;
   localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
   typedef enum logic [1:0] {IDLE, DRAIN, WAIT_ACK} state_t;
   typedef struct packed {
      logic [2:0]  type_;
      logic [7:0]  opaque;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_req_4B_t;
   typedef struct packed {
      logic [2:0]  type_;
      logic [7:0]  opaque;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_resp_4B_t;
endpackage

// File: rtl/lab3_cache_victim_buffer_if.sv
// lab3_cache_victim_buffer_if: bundle of the victim buffer's cache-side and memory-side signals
//   victim_*  : line hand-off from the cache (val/rdy, line address, 512-bit data)
//   memreq_*  : word write requests to memory
//   memresp_* : write acks from memory
//   lookup_*  : refill-path probe of the held line; busy flags a line in flight
//   master modport = cache/memory environment, slave modport = victim buffer
interface lab3_cache_victim_buffer_if;
   import lab3_cache_victim_buffer_pkg::*;
   logic         victim_val;
   logic         victim_rdy;
   logic [31:0]  victim_addr;
   logic [511:0] victim_data;
   logic         memreq_val;
   logic         memreq_rdy;
   mem_req_4B_t  memreq_msg;
   logic         memresp_val;
   logic         memresp_rdy;
   mem_resp_4B_t memresp_msg;
   logic [31:0]  lookup_addr;
   logic         lookup_match;
   logic         busy;
   modport master (
      output victim_val, victim_addr, victim_data, memreq_rdy, memresp_val, memresp_msg, lookup_addr,
      input  victim_rdy, memreq_val, memreq_msg, memresp_rdy, lookup_match, busy
   );
   modport slave (
      input  victim_val, victim_addr, victim_data, memreq_rdy, memresp_val, memresp_msg, lookup_addr,
      output victim_rdy, memreq_val, memreq_msg, memresp_rdy, lookup_match, busy
   );
endinterface

// File: rtl/lab3_cache_victim_word_sel.sv
// lab3_cache_victim_word_sel: picks 32-bit word idx out of a 512-bit cache line
//   line_data : held line, word i in bits [32i+31:32i]
//   idx       : word index
//   word      : selected word
module lab3_cache_victim_word_sel (
   input  logic [511:0] line_data,
   input  logic [3:0]   idx,
   output logic [31:0]  word
);
   assign word = line_data[{idx, 5'b0} +: 32];
endmodule

// File: rtl/lab3_cache_victim_buffer.sv
// lab3_cache_victim_buffer: single-line write-back victim buffer draining an evicted line as 16 word writes
//   clk, reset : clock and asynchronous active-high reset
//   bus        : slave side of lab3_cache_victim_buffer_if (victim hand-off, memory write port, lookup probe)
module lab3_cache_victim_buffer
   import lab3_cache_victim_buffer_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input logic clk,
   input logic reset,
   lab3_cache_victim_buffer_if.slave bus
);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);
   localparam logic [3:0] LAST_IDX = 4'(WORDS_PER_LINE - 1);
   state_t state, state_n;
   logic [31-LINE_OFFSET_BITS:0] line;
   logic [WORDS_PER_LINE*32-1:0] data;
   logic [3:0] send_idx;
   logic [4:0] ack_cnt;
   logic [OW-1:0] outstanding;
   logic [31:0] word;
   logic capture, req_fire, resp_fire, last_req, last_ack;
   logic unused;
   assign unused = ^{bus.victim_addr[LINE_OFFSET_BITS-1:0], bus.memresp_msg};
   lab3_cache_victim_word_sel u_word_sel (.line_data(data), .idx(send_idx), .word(word));
   always_comb begin
      bus.victim_rdy = state == IDLE;
      bus.busy = state != IDLE;
      bus.memreq_val = state == DRAIN && outstanding < MAX_O;
      bus.memresp_rdy = state != IDLE && outstanding != '0;
      bus.lookup_match = state != IDLE && bus.lookup_addr[31:LINE_OFFSET_BITS] == line;
      bus.memreq_msg = '0;
      if (state == DRAIN) begin
         bus.memreq_msg.type_ = MEM_TYPE_WRITE;
         bus.memreq_msg.opaque = {4'b0, send_idx};
         bus.memreq_msg.addr = {line, send_idx, 2'b00};
         bus.memreq_msg.data = word;
      end
      capture = state == IDLE && bus.victim_val;
      req_fire = bus.memreq_val && bus.memreq_rdy;
      resp_fire = bus.memresp_val && bus.memresp_rdy;
      last_req = req_fire && send_idx == LAST_IDX;
      last_ack = resp_fire && ack_cnt == 5'(LAST_IDX);
      // The DRAIN->IDLE shortcut only matters if memory acks the 16th write in the cycle it is issued.
      state_n = state == IDLE  ? (capture ? DRAIN : IDLE) :
                state == DRAIN ? (last_req ? (last_ack ? IDLE : WAIT_ACK) : DRAIN) :
                                 (last_ack ? IDLE : WAIT_ACK);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         line <= '0;
         data <= '0;
         send_idx <= '0;
         ack_cnt <= '0;
         outstanding <= '0;
      end else begin
         state <= state_n;
         if (capture) begin
            line <= bus.victim_addr[31:LINE_OFFSET_BITS];
            data <= bus.victim_data;
            send_idx <= '0;
            ack_cnt <= '0;
            outstanding <= '0;
         end else begin
            send_idx <= send_idx + 4'(req_fire);
            ack_cnt <= ack_cnt + 5'(resp_fire);
            outstanding <= outstanding + OW'(req_fire) - OW'(resp_fire);
         end
      end
   end
endmodule

// File: tb/tb_lab3_cache_victim_buffer.sv
// tb_lab3_cache_victim_buffer: directed self-checking bench for the victim buffer (MAX_OUTSTANDING=2)
module tb_lab3_cache_victim_buffer;
   import lab3_cache_victim_buffer_pkg::*;
   logic clk = 1'b0;
   logic reset;
   int n_cmp = 0;
   int n_bad = 0;
   always #5 clk = ~clk;
   lab3_cache_victim_buffer_if bus ();
   lab3_cache_victim_buffer #(.MAX_OUTSTANDING(2)) dut (.clk(clk), .reset(reset), .bus(bus));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic load_victim(input logic [31:0] addr, input logic [31:0] w0, input bit hold);
      bus.victim_addr = addr;
      for (int i = 0; i < 16; i++) bus.victim_data[32*i +: 32] = w0 + 32'(i);
      bus.victim_val = 1'b1;
      #1;
      chk("victim_rdy_before_capture", 32'(bus.victim_rdy), 32'd1);
      @(negedge clk);
      bus.victim_val = hold;
      #1;
      chk("busy_after_capture", 32'(bus.busy), 32'd1);
      chk("memreq_val_after_capture", 32'(bus.memreq_val), 32'd1);
      @(negedge clk);
   endtask

   // Drives memory with 1-cycle acks; mode 1 toggles memreq_rdy every other cycle.
   task automatic run_drain(input logic [31:0] base, input logic [31:0] w0, input int mode,
                            input int idx0, input int pend0, output int busy_cycles);
      int idx = idx0;
      int pend = pend0;
      int cyc = 0;
      mem_req_4B_t exp;
      busy_cycles = 0;
      while (bus.busy && cyc < 200) begin
         bus.memresp_val = pend > 0;
         bus.memreq_rdy = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
         #1;
         busy_cycles++;
         chk("victim_rdy_while_busy", 32'(bus.victim_rdy), 32'd0);
         if (bus.memreq_val && bus.memreq_rdy) begin
            exp.type_ = 3'd1;
            exp.opaque = 8'(idx);
            exp.addr = base + 32'(4 * idx);
            exp.len = 2'd0;
            exp.data = w0 + 32'(idx);
            n_cmp++;
            if (bus.memreq_msg !== exp) begin
               n_bad++;
               $display("FAIL memreq_msg[%0d]: got %h want %h", idx, bus.memreq_msg, exp);
            end
            idx++;
            pend++;
         end
         if (bus.memresp_val && bus.memresp_rdy) pend--;
         cyc++;
         @(negedge clk);
      end
      bus.memresp_val = 1'b0;
      bus.memreq_rdy = 1'b0;
      if (cyc >= 200) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got busy after %0d cycles want idle", cyc);
      end
      chk("words_sent", 32'(idx), 32'd16);
      chk("acks_left", 32'(pend), 32'd0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.victim_val = 1'b0;
      bus.victim_addr = '0;
      bus.victim_data = '0;
      bus.memreq_rdy = 1'b0;
      bus.memresp_val = 1'b0;
      bus.memresp_msg = '0;
      bus.lookup_addr = '0;
      repeat (2) @(negedge clk);
      chk("rst_victim_rdy", 32'(bus.victim_rdy), 32'd1);
      chk("rst_memreq_val", 32'(bus.memreq_val), 32'd0);
      chk("rst_memresp_rdy", 32'(bus.memresp_rdy), 32'd0);
      chk("rst_lookup_match", 32'(bus.lookup_match), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      n_cmp++;
      if (bus.memreq_msg !== '0) begin
         n_bad++;
         $display("FAIL rst_memreq_msg: got %h want 0", bus.memreq_msg);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      int bc;
      load_victim(32'h0000_1040, 32'hA000_0000, 1'b0);
      run_drain(32'h0000_1040, 32'hA000_0000, 0, 0, 0, bc);
      chk("single_busy_cycles", 32'(bc), 32'd17);
      chk("single_victim_rdy_after", 32'(bus.victim_rdy), 32'd1);
   endtask

   task automatic test_credit_lookup();
      int fired = 0;
      int bc;
      load_victim(32'h0000_1040, 32'hB000_0000, 1'b0);
      bus.memresp_val = 1'b0;
      bus.memreq_rdy = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (bus.memreq_val && bus.memreq_rdy) fired++;
         @(negedge clk);
      end
      chk("credit_stall_count", 32'(fired), 32'd2);
      #1;
      chk("credit_stall_val", 32'(bus.memreq_val), 32'd0);
      bus.lookup_addr = 32'h0000_1058;
      #1;
      chk("lookup_same_line", 32'(bus.lookup_match), 32'd1);
      bus.lookup_addr = 32'h0000_1080;
      #1;
      chk("lookup_other_line", 32'(bus.lookup_match), 32'd0);
      bus.memresp_val = 1'b1;
      @(negedge clk);
      bus.memresp_val = 1'b0;
      fired = 0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (bus.memreq_val && bus.memreq_rdy) fired++;
         @(negedge clk);
      end
      chk("credit_one_more", 32'(fired), 32'd1);
      run_drain(32'h0000_1040, 32'hB000_0000, 0, 3, 2, bc);
      bus.lookup_addr = 32'h0000_1058;
      #1;
      chk("lookup_after_idle", 32'(bus.lookup_match), 32'd0);
      @(negedge clk);
   endtask

   task automatic test_rdy_toggle();
      int bc;
      load_victim(32'h0000_2000, 32'hC000_0000, 1'b0);
      run_drain(32'h0000_2000, 32'hC000_0000, 1, 0, 0, bc);
      chk("toggle_victim_rdy_after", 32'(bus.victim_rdy), 32'd1);
   endtask

   task automatic test_back_to_back();
      int bc;
      load_victim(32'h0000_3000, 32'hD000_0000, 1'b1);
      bus.victim_addr = 32'h0000_4000;
      for (int i = 0; i < 16; i++) bus.victim_data[32*i +: 32] = 32'hE000_0000 + 32'(i);
      run_drain(32'h0000_3000, 32'hD000_0000, 0, 0, 0, bc);
      chk("b2b_idle_rdy", 32'(bus.victim_rdy), 32'd1);
      chk("b2b_gap_no_req", 32'(bus.memreq_val), 32'd0);
      @(negedge clk);
      bus.victim_val = 1'b0;
      chk("b2b_second_captured", 32'(bus.busy), 32'd1);
      run_drain(32'h0000_4000, 32'hE000_0000, 0, 0, 0, bc);
      chk("b2b_second_busy_cycles", 32'(bc), 32'd17);
   endtask

   task automatic test_reset_mid_drain();
      int fired = 0;
      int pend = 0;
      int cyc = 0;
      int bc;
      load_victim(32'h0000_5000, 32'hF000_0000, 1'b0);
      while (fired < 5 && cyc < 50) begin
         bus.memresp_val = pend > 0;
         bus.memreq_rdy = 1'b1;
         #1;
         if (bus.memreq_val && bus.memreq_rdy) begin
            fired++;
            pend++;
         end
         if (bus.memresp_val && bus.memresp_rdy) pend--;
         cyc++;
         @(negedge clk);
      end
      chk("mid_requests_before_reset", 32'(fired), 32'd5);
      bus.lookup_addr = 32'h0000_5000;
      #1;
      chk("mid_lookup_before_reset", 32'(bus.lookup_match), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_victim_rdy", 32'(bus.victim_rdy), 32'd1);
      chk("mid_rst_memreq_val", 32'(bus.memreq_val), 32'd0);
      chk("mid_rst_memresp_rdy", 32'(bus.memresp_rdy), 32'd0);
      chk("mid_rst_lookup_match", 32'(bus.lookup_match), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      n_cmp++;
      if (bus.memreq_msg !== '0) begin
         n_bad++;
         $display("FAIL mid_rst_memreq_msg: got %h want 0", bus.memreq_msg);
      end
      bus.memresp_val = 1'b0;
      bus.memreq_rdy = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      load_victim(32'h0000_6000, 32'h1234_0000, 1'b0);
      run_drain(32'h0000_6000, 32'h1234_0000, 0, 0, 0, bc);
      chk("mid_new_busy_cycles", 32'(bc), 32'd17);
   endtask

   initial begin
      test_reset();
      test_single();
      test_credit_lookup();
      test_rdy_toggle();
      test_back_to_back();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
